// File: rtl/vx_alu_dot8_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_dot8_pipe_pkg
// Purpose : Shared constants and the signed byte multiply helper for the
//           INST_ALU_DOT8 processing element.
// Contents: DOT8_LATENCY  - accept-to-result latency seen by switch/scoreboard
//           DOT8_BYTES    - int8 elements per 32-bit operand word
//           DEF_*         - default lane count / register width / tag width
//           dot8_mul()    - signed 8x8 -> 16 multiply
// Revision: 1.0 - initial release
// ============================================================================
package vx_alu_dot8_pipe_pkg;

    localparam int DOT8_LATENCY  = 2;
    localparam int DOT8_BYTES    = 4;
    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_XLEN      = 32;
    localparam int DEF_TAG_W     = 64;

    // The full int8*int8 product (-16256..16384) always fits in 16 signed
    // bits, so a 16-bit wrap-around multiply is exact.
    function automatic logic signed [15:0] dot8_mul(input logic [7:0] a,
                                                    input logic [7:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = 16'($signed(a));
        sb = 16'($signed(b));
        return sa * sb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_alu_dot8_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_dot8_pipe_if
// Purpose : Execute/result handshake between the ALU PE switch (master) and
//           the DOT8 processing element (slave).
// Signals : execute_valid/ready, execute_tmask, execute_rs1/rs2, execute_tag
//           result_valid/ready, result_data, result_tag
// Revision: 1.0 - initial release
// ============================================================================
interface vx_alu_dot8_pipe_if
    import vx_alu_dot8_pipe_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int XLEN      = DEF_XLEN,
    parameter int TAG_W     = DEF_TAG_W
);
    logic                      execute_valid;
    logic [NUM_LANES-1:0]      execute_tmask;
    logic [NUM_LANES*XLEN-1:0] execute_rs1;
    logic [NUM_LANES*XLEN-1:0] execute_rs2;
    logic [TAG_W-1:0]          execute_tag;
    logic                      execute_ready;

    logic                      result_valid;
    logic [NUM_LANES*XLEN-1:0] result_data;
    logic [TAG_W-1:0]          result_tag;
    logic                      result_ready;

    modport master (
        output execute_valid, execute_tmask, execute_rs1, execute_rs2, execute_tag,
        input  execute_ready,
        input  result_valid, result_data, result_tag,
        output result_ready
    );

    modport slave (
        input  execute_valid, execute_tmask, execute_rs1, execute_rs2, execute_tag,
        output execute_ready,
        output result_valid, result_data, result_tag,
        input  result_ready
    );
endinterface
`default_nettype wire

// File: rtl/vx_dot8_lane.sv
`default_nettype none
// ============================================================================
// Module  : vx_dot8_lane
// Purpose : One lane of the DOT8 pipe. S1 registers the four signed byte
//           products and the lane mask; S2 registers the sign-extended sum.
// Ports   : clk, reset (async active-low), adv (pipe advance enable),
//           mask (lane active), rs1/rs2 (packed 4 x int8), lane_sum (S2 out)
// Revision: 1.0 - initial release
// ============================================================================
module vx_dot8_lane
    import vx_alu_dot8_pipe_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            adv,
    input  wire logic            mask,
    input  wire logic [31:0]     rs1,
    input  wire logic [31:0]     rs2,
    output logic      [XLEN-1:0] lane_sum
);
    logic signed [15:0] r_prod [DOT8_BYTES];
    logic               r_mask;
    logic [XLEN-1:0]    r_sum;
    logic signed [17:0] w_sum;

    // 18 bits hold the extreme 4 * 16384 = 65536 without overflow.
    assign w_sum = 18'(r_prod[0]) + 18'(r_prod[1]) + 18'(r_prod[2]) + 18'(r_prod[3]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DOT8_BYTES; k++) begin
                r_prod[k] <= '0;
            end
            r_mask <= 1'b0;
            r_sum  <= '0;
        end else if (adv) begin
            for (int k = 0; k < DOT8_BYTES; k++) begin
                r_prod[k] <= dot8_mul(rs1[8*k +: 8], rs2[8*k +: 8]);
            end
            r_mask <= mask;
            r_sum  <= r_mask ? XLEN'(w_sum) : '0;
        end
    end

    assign lane_sum = r_sum;
endmodule
`default_nettype wire

// File: rtl/vx_alu_dot8_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vx_alu_dot8_pipe
// Purpose : INST_ALU_DOT8 processing element. Per lane, signed 4-way int8 dot
//           product through a 2-stage elastic pipeline; tag passed through.
// Ports   : clk, reset (async active-low)
//           bus      - slave side of the execute/result handshake
//           busy     - any stage holds a valid beat
//           perf_ops - count of result handshakes (wraps)
// Revision: 1.0 - initial release
// ============================================================================
module vx_alu_dot8_pipe
    import vx_alu_dot8_pipe_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int XLEN      = DEF_XLEN,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    vx_alu_dot8_pipe_if.slave bus,
    output logic             busy,
    output logic [31:0]      perf_ops
);
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [TAG_W-1:0] r_s1_tag;
    logic [TAG_W-1:0] r_s2_tag;
    logic [31:0]      r_perf_ops;
    logic             w_stall;
    logic             w_adv;
    logic [NUM_LANES*XLEN-1:0] w_lane_data;

    // Whole pipe moves as one unit; it only freezes while S2 cannot hand off.
    assign w_stall = r_s2_valid && !bus.result_ready;
    assign w_adv   = !w_stall;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            vx_dot8_lane #(.XLEN(XLEN)) u_lane (
                .clk      (clk),
                .reset    (reset),
                .adv      (w_adv),
                .mask     (bus.execute_tmask[i]),
                .rs1      (bus.execute_rs1[i*XLEN +: 32]),
                .rs2      (bus.execute_rs2[i*XLEN +: 32]),
                .lane_sum (w_lane_data[i*XLEN +: XLEN])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_tag   <= '0;
            r_perf_ops <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid <= bus.execute_valid;
                r_s1_tag   <= bus.execute_tag;
                r_s2_valid <= r_s1_valid;
                r_s2_tag   <= r_s1_tag;
            end
            if (r_s2_valid && bus.result_ready) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
        end
    end

    assign bus.execute_ready = w_adv;
    assign bus.result_valid  = r_s2_valid;
    assign bus.result_data   = w_lane_data;
    assign bus.result_tag    = r_s2_tag;
    assign busy              = r_s1_valid | r_s2_valid;
    assign perf_ops          = r_perf_ops;
endmodule
`default_nettype wire
